// File: rtl/rs_issue_unit_pkg.sv
// Shared opcode constants, ready-tag constant and opcode-to-pool classification
// for the reservation-station issue unit.
package rs_issue_unit_pkg;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_SUB = 8'h02;
   localparam logic [7:0] OP_MUL = 8'h03;

   localparam int TAG_READY = 0;

   typedef enum logic [1:0] {
      POOL_NONE = 2'd0,
      POOL_ADD  = 2'd1,
      POOL_MUL  = 2'd2
   } pool_e;

   // Anything that is not a recognised arithmetic opcode behaves as a NOP.
   function automatic pool_e pool_of(input logic [7:0] op);
      case (op)
         OP_ADD, OP_SUB: pool_of = POOL_ADD;
         OP_MUL:         pool_of = POOL_MUL;
         default:        pool_of = POOL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/rs_issue_unit_if.sv
// Decode-to-issue handshake, dispatch packet and CDB broadcast bundle.
// master = decoder/environment side, slave = rs_issue_unit.
interface rs_issue_unit_if #(parameter int TAG_W = 4);

   logic [1:0]       inst_valid;
   logic [7:0]       inst1_type, inst1_dest, inst1_src1, inst1_src2;
   logic [7:0]       inst2_type, inst2_dest, inst2_src1, inst2_src2;
   logic [1:0]       issue_ack;
   logic             AR_Status;
   logic             MR_Status;

   logic [1:0]       disp_valid;
   logic [7:0]       disp1_type, disp2_type;
   logic [TAG_W-1:0] disp1_tag, disp2_tag;
   logic [TAG_W-1:0] disp1_qj, disp1_qk, disp2_qj, disp2_qk;
   logic [7:0]       disp1_src1, disp1_src2, disp2_src1, disp2_src2;

   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;

   modport master (
      output inst_valid, inst1_type, inst1_dest, inst1_src1, inst1_src2,
             inst2_type, inst2_dest, inst2_src1, inst2_src2,
             cdb_valid, cdb_tag,
      input  issue_ack, AR_Status, MR_Status,
             disp_valid, disp1_type, disp2_type, disp1_tag, disp2_tag,
             disp1_qj, disp1_qk, disp2_qj, disp2_qk,
             disp1_src1, disp1_src2, disp2_src1, disp2_src2
   );

   modport slave (
      input  inst_valid, inst1_type, inst1_dest, inst1_src1, inst1_src2,
             inst2_type, inst2_dest, inst2_src1, inst2_src2,
             cdb_valid, cdb_tag,
      output issue_ack, AR_Status, MR_Status,
             disp_valid, disp1_type, disp2_type, disp1_tag, disp2_tag,
             disp1_qj, disp1_qk, disp2_qj, disp2_qk,
             disp1_src1, disp1_src2, disp2_src1, disp2_src2
   );

endinterface

// File: rtl/rs_free_picker.sv
// Finds the lowest and second-lowest free entries of one reservation-station pool.
module rs_free_picker #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     busy,
   output logic [IDX_W-1:0] first_idx,
   output logic [IDX_W-1:0] second_idx,
   output logic             has_one,
   output logic             has_two
);

   always_comb begin
      first_idx  = '0;
      second_idx = '0;
      has_one    = 1'b0;
      has_two    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!busy[i]) begin
            if (!has_one) begin
               first_idx = IDX_W'(i);
               has_one   = 1'b1;
            end else if (!has_two) begin
               second_idx = IDX_W'(i);
               has_two    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rs_issue_unit.sv
// Dual-issue RS allocator with RAT renaming and registered dispatch packets.
// Optional RS_ISSUE_STATS_EN adds stall / dual-issue saturating counters.
module rs_issue_unit
   import rs_issue_unit_pkg::*;
#(
   parameter int ADD_RS   = 3,
   parameter int MUL_RS   = 2,
   parameter int NUM_REGS = 16,
   parameter int TAG_W    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   rs_issue_unit_if.slave bus
`ifdef RS_ISSUE_STATS_EN
   ,
   output logic [15:0]   stall_cycles,
   output logic [15:0]   dual_issue_cycles
`endif
);

   localparam int RW = $clog2(NUM_REGS);
   localparam int AW = (ADD_RS > 1) ? $clog2(ADD_RS) : 1;
   localparam int MW = (MUL_RS > 1) ? $clog2(MUL_RS) : 1;
   localparam logic [TAG_W-1:0] TAG_ZERO = TAG_W'(TAG_READY);
   localparam logic [TAG_W-1:0] MUL_BASE = TAG_W'(ADD_RS + 1);
   localparam logic [TAG_W-1:0] TAG_MAX  = TAG_W'(ADD_RS + MUL_RS);

   logic [ADD_RS-1:0] add_busy_q, add_busy_d;
   logic [MUL_RS-1:0] mul_busy_q, mul_busy_d;
   logic [TAG_W-1:0]  rat_q [NUM_REGS];
   logic [TAG_W-1:0]  rat_d [NUM_REGS];

   logic [AW-1:0] add_first, add_second;
   logic [MW-1:0] mul_first, mul_second;
   logic          add_one, add_two, mul_one, mul_two;

   pool_e            pool1, pool2;
   logic             ok1, ok2, ack1, ack2, alloc1, alloc2;
   logic [AW-1:0]    add_idx2;
   logic [MW-1:0]    mul_idx2;
   logic [TAG_W-1:0] tag1, tag2;
   logic [TAG_W-1:0] qj1, qk1, qj2, qk2;
   logic [RW-1:0]    dest1, dest2;
   logic             cdb_hit;
   logic             unused_dest_hi;

   rs_free_picker #(.N(ADD_RS)) u_add_pick (
      .busy       (add_busy_q),
      .first_idx  (add_first),
      .second_idx (add_second),
      .has_one    (add_one),
      .has_two    (add_two)
   );

   rs_free_picker #(.N(MUL_RS)) u_mul_pick (
      .busy       (mul_busy_q),
      .first_idx  (mul_first),
      .second_idx (mul_second),
      .has_one    (mul_one),
      .has_two    (mul_two)
   );

   assign dest1          = bus.inst1_dest[RW-1:0];
   assign dest2          = bus.inst2_dest[RW-1:0];
   assign unused_dest_hi = ^{bus.inst1_dest[7:RW], bus.inst2_dest[7:RW]};
   assign cdb_hit        = bus.cdb_valid && (bus.cdb_tag != TAG_ZERO) && (bus.cdb_tag <= TAG_MAX);

   function automatic logic [TAG_W-1:0] cdb_bypass(input logic [TAG_W-1:0] t,
                                                   input logic             hit,
                                                   input logic [TAG_W-1:0] ctag);
      return (hit && t == ctag) ? TAG_ZERO : t;
   endfunction

   always_comb begin
      pool1    = pool_of(bus.inst1_type);
      pool2    = pool_of(bus.inst2_type);
      ok2      = 1'b1;
      tag2     = TAG_ZERO;
      add_idx2 = add_first;
      mul_idx2 = mul_first;

      ok1    = (pool1 == POOL_NONE) || ((pool1 == POOL_ADD) ? add_one : mul_one);
      ack1   = bus.inst_valid[0] && ok1;
      alloc1 = ack1 && (pool1 != POOL_NONE);
      tag1   = (pool1 == POOL_ADD) ? TAG_W'(add_first) + TAG_W'(1)
                                   : MUL_BASE + TAG_W'(mul_first);

      // inst2 only reaches the second free entry when inst1 took the first one of its pool
      if (pool2 == POOL_ADD) begin
         ok2      = (pool1 == POOL_ADD) ? add_two : add_one;
         add_idx2 = (pool1 == POOL_ADD) ? add_second : add_first;
         tag2     = TAG_W'(add_idx2) + TAG_W'(1);
      end else if (pool2 == POOL_MUL) begin
         ok2      = (pool1 == POOL_MUL) ? mul_two : mul_one;
         mul_idx2 = (pool1 == POOL_MUL) ? mul_second : mul_first;
         tag2     = MUL_BASE + TAG_W'(mul_idx2);
      end
      ack2   = ack1 && bus.inst_valid[1] && ok2;
      alloc2 = ack2 && (pool2 != POOL_NONE);

      qj1 = cdb_bypass(rat_q[bus.inst1_src1[RW-1:0]], cdb_hit, bus.cdb_tag);
      qk1 = cdb_bypass(rat_q[bus.inst1_src2[RW-1:0]], cdb_hit, bus.cdb_tag);
      qj2 = cdb_bypass(rat_q[bus.inst2_src1[RW-1:0]], cdb_hit, bus.cdb_tag);
      qk2 = cdb_bypass(rat_q[bus.inst2_src2[RW-1:0]], cdb_hit, bus.cdb_tag);
      if (alloc1 && bus.inst2_src1[RW-1:0] == dest1) qj2 = tag1;
      if (alloc1 && bus.inst2_src2[RW-1:0] == dest1) qk2 = tag1;
   end

   assign bus.issue_ack = {ack2, ack1};

   // CDB clears are applied first so same-edge allocations and RAT writes win.
   always_comb begin
      add_busy_d = add_busy_q;
      mul_busy_d = mul_busy_q;
      rat_d      = rat_q;
      if (cdb_hit) begin
         for (int i = 0; i < ADD_RS; i++)
            if (bus.cdb_tag == TAG_W'(i + 1)) add_busy_d[i] = 1'b0;
         for (int i = 0; i < MUL_RS; i++)
            if (bus.cdb_tag == MUL_BASE + TAG_W'(i)) mul_busy_d[i] = 1'b0;
         for (int r = 0; r < NUM_REGS; r++)
            if (rat_q[r] == bus.cdb_tag) rat_d[r] = TAG_ZERO;
      end
      if (alloc1) begin
         if (pool1 == POOL_ADD) add_busy_d[add_first] = 1'b1;
         else                   mul_busy_d[mul_first] = 1'b1;
         rat_d[dest1] = tag1;
      end
      if (alloc2) begin
         if (pool2 == POOL_ADD) add_busy_d[add_idx2] = 1'b1;
         else                   mul_busy_d[mul_idx2] = 1'b1;
         rat_d[dest2] = tag2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_busy_q     <= '0;
         mul_busy_q     <= '0;
         for (int r = 0; r < NUM_REGS; r++) rat_q[r] <= '0;
         bus.AR_Status  <= 1'b0;
         bus.MR_Status  <= 1'b0;
         bus.disp_valid <= '0;
         bus.disp1_type <= '0;
         bus.disp1_tag  <= '0;
         bus.disp1_qj   <= '0;
         bus.disp1_qk   <= '0;
         bus.disp1_src1 <= '0;
         bus.disp1_src2 <= '0;
         bus.disp2_type <= '0;
         bus.disp2_tag  <= '0;
         bus.disp2_qj   <= '0;
         bus.disp2_qk   <= '0;
         bus.disp2_src1 <= '0;
         bus.disp2_src2 <= '0;
      end else begin
         add_busy_q     <= add_busy_d;
         mul_busy_q     <= mul_busy_d;
         rat_q          <= rat_d;
         bus.AR_Status  <= &add_busy_d;
         bus.MR_Status  <= &mul_busy_d;
         bus.disp_valid <= {alloc2, alloc1};
         bus.disp1_type <= alloc1 ? bus.inst1_type : '0;
         bus.disp1_tag  <= alloc1 ? tag1 : '0;
         bus.disp1_qj   <= alloc1 ? qj1 : '0;
         bus.disp1_qk   <= alloc1 ? qk1 : '0;
         bus.disp1_src1 <= alloc1 ? bus.inst1_src1 : '0;
         bus.disp1_src2 <= alloc1 ? bus.inst1_src2 : '0;
         bus.disp2_type <= alloc2 ? bus.inst2_type : '0;
         bus.disp2_tag  <= alloc2 ? tag2 : '0;
         bus.disp2_qj   <= alloc2 ? qj2 : '0;
         bus.disp2_qk   <= alloc2 ? qk2 : '0;
         bus.disp2_src1 <= alloc2 ? bus.inst2_src1 : '0;
         bus.disp2_src2 <= alloc2 ? bus.inst2_src2 : '0;
      end
   end

`ifdef RS_ISSUE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles      <= '0;
         dual_issue_cycles <= '0;
      end else begin
         if (bus.inst_valid[0] && !ack1 && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
         if (ack1 && ack2 && dual_issue_cycles != 16'hFFFF)
            dual_issue_cycles <= dual_issue_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: doc/rs_issue_unit.md
Name: rs_issue_unit

Overview:
- Consumer end of the dual-issue decode interface, feeding the Tomasulo core.
- Each cycle it accepts up to two decoded instructions in program order and allocates add/mul reservation-station (RS) entries.
- Renames sources through a register alias table (RAT) and emits registered dispatch packets.
- Returns AR_Status/MR_Status (RS-full flags) upstream to the decoder; entries and RAT tags are freed by common-data-bus (CDB) broadcasts.

Parameters:
ADD_RS, 3, number of add/sub RS entries
MUL_RS, 2, number of mul RS entries
NUM_REGS, 16, architectural registers; reg fields index with low log2(NUM_REGS) bits
TAG_W, 4, tag width; tag 0 = "value ready", 1..ADD_RS = add entries, ADD_RS+1..ADD_RS+MUL_RS = mul entries

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst_valid  in  2  bit0 = inst1 slot valid, bit1 = inst2 slot valid
inst1_type / inst2_type  in  8  opcode (NOP/ADD/SUB/MUL)
inst1_dest, inst1_src1, inst1_src2 / inst2_dest, inst2_src1, inst2_src2  in  8 each  register fields
issue_ack  out  2  combinational; slots accepted this cycle
AR_Status  out  1  registered; 1 = all add RS entries busy
MR_Status  out  1  registered; 1 = all mul RS entries busy
disp_valid  out  2  registered; dispatch packet valid per slot
disp1_type/disp2_type  out  8  opcode of dispatched instruction
disp1_tag/disp2_tag  out  TAG_W  allocated RS entry
disp1_qj, disp1_qk, disp2_qj, disp2_qk  out  TAG_W  producer tags of sources (0 = ready)
disp1_src1, disp1_src2, disp2_src1, disp2_src2  out  8  source register numbers, passed through
cdb_valid  in  1  completion broadcast
cdb_tag  in  TAG_W  completing tag

Behaviour:
- Reset (async, rst_n=0): all RS busy bits 0; RAT entries 0; AR_Status=MR_Status=0; disp_valid=0; all disp_* fields 0. Reset asserted mid-operation discards every in-flight allocation.
- Class: ADD/SUB -> add pool; MUL -> mul pool; NOP -> no pool, always acceptable, no dispatch. Unknown opcode is treated as NOP.
- Free-entry selection uses registered busy bits only.
  - An entry freed by the CDB in cycle N is allocatable no earlier than cycle N+1.
  - Lowest-index free entry goes to inst1; next-lowest in the same pool goes to inst2.
- In-order acceptance:
  - issue_ack[0] = inst_valid[0] && (NOP || pool has >=1 free entry).
  - issue_ack[1] = issue_ack[0] && inst_valid[1] && (NOP || pool has >=1 free entry after inst1's allocation).
  - inst2 is never accepted without inst1.
- Upstream handshake:
  - Slots are held until acked.
  - If only inst1 is acked, upstream moves inst2 into slot 1 next cycle.
  - The block keeps no instruction storage of its own.
- On an accepted non-NOP slot at the clock edge:
  - Set its entry busy.
  - Load disp_valid=1 and disp_* fields; dispatch latency is 1 cycle.
  - Write RAT[dest]=tag.
- Source renaming:
  - qj/qk = RAT[src] read pre-edge.
  - For inst2, if a source equals inst1's dest and inst1 is accepted non-NOP, qj/qk takes inst1's new tag (intra-pair bypass).
  - A source whose RAT tag equals cdb_tag with cdb_valid in the same cycle yields 0 (CDB bypass).
- CDB (cdb_valid=1):
  - Clear busy[cdb_tag].
  - Clear every RAT entry holding cdb_tag.
  - Same-cycle RAT write by a new issue wins over the clear.
  - cdb_tag=0 or out of range is ignored.
- WAW within a pair: inst1 and inst2 with the same dest -> RAT holds inst2's tag.
- AR_Status/MR_Status: recomputed every cycle from next-state busy bits, i.e. they reflect allocations and frees made at that edge.
- Non-acked or NOP slots produce disp_valid=0 for that slot the next cycle.

Optional Feature:
- Macro: RS_ISSUE_STATS_EN.
- Defined: adds outputs stall_cycles[15:0] and dual_issue_cycles[15:0].
  - stall_cycles: saturating count of cycles where inst_valid[0]=1 and issue_ack[0]=0.
  - dual_issue_cycles: saturating count of cycles where issue_ack=2'b11.
  - Both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: opcode constants (NOP=8'h00, ADD=8'h01, SUB=8'h02, MUL=8'h03), tag-0 constant, and the pool-class function (opcode -> add/mul/none).
- Sub-module rs_free_picker, instantiated once per pool: given a busy vector, returns first- and second-lowest free index plus count>=1 and >=2 flags.

Test Plan:
- Reset, then pair ADD r1,r2,r3 / MUL r4,r1,r5 -> issue_ack=11 same cycle. Next cycle:
  - disp1_tag=1, qj=qk=0.
  - disp2_tag=4, disp2_qj=1 (bypass), disp2_qk=0.
  - AR_Status=0, MR_Status=0.
- Three MULs in consecutive single slots, no CDB -> first two acked with tags 4 and 5; MR_Status=1 after the second; third held with issue_ack=00 until cdb_tag=4, then acked the following cycle with tag 4.
- Pair ADD,ADD with two add entries already busy -> issue_ack=01, AR_Status=1 next cycle; upstream shifts inst2 into slot 1 and it stalls until a CDB frees an add entry.
- CDB cdb_tag=1 in the same cycle a new ADD writes r1 -> RAT[r1] holds the new tag; a following read of r1 returns the new tag, not 0.
- Pair ADD r7 / SUB r7 -> later read of r7 gives the SUB's tag. Separately, assert rst_n=0 mid-stream -> all outputs 0 immediately (async); first pair after release gets tags 1 and 2.
- With RS_ISSUE_STATS_EN defined: 5 stalled cycles and 3 dual-issue cycles -> stall_cycles=5, dual_issue_cycles=3; counters hold at 16'hFFFF on overflow.
